fft256_seq_ctrl: RTL and testbench

//  Sequencer for the in-place 256-point radix-2 DIF FFT core.

---
 rtl/fft256_pkg.sv | 30 +++
 rtl/fft256_seq_ctrl_if.sv | 41 ++++
 rtl/fft256_bf_addr_gen.sv | 26 ++
 rtl/fft256_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_fft256_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fft256_pkg.sv
// Shared types and constants for the 256-point radix-2 DIF FFT sequencer.
// Contains the address/twiddle widths, the FSM state type and the output bit-reversal helper.
package fft256_pkg;

    localparam int N     = 256;
    localparam int LOG2N = 8;
    localparam int HALF  = 128;

    typedef logic [7:0] addr_t;
    typedef logic [6:0] tw_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        DRAIN,
        OUT,
        TAIL
    } state_t;

    function automatic addr_t bitrev8(input addr_t k);
        addr_t r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = k[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft256_seq_ctrl_if.sv
// Bundle of sample-load, butterfly and output-stream control lines of the FFT sequencer.
// The master modport is the sequencer; the slave modport is the RAM/datapath side.
interface fft256_seq_ctrl_if;
    import fft256_pkg::*;

    logic  in_valid;
    logic  ld_wr_en;
    addr_t ld_addr;
    logic  bf_rd_en;
    addr_t bf_addr_a;
    addr_t bf_addr_b;
    tw_t   tw_idx;
    logic [2:0] bf_stage;
    logic  bf_wr_en;
    addr_t bf_wr_a;
    addr_t bf_wr_b;
    logic  out_rd_en;
    addr_t out_addr;
    logic  out_valid;
    logic  busy;
    logic  in_drop;

    modport master (
        input  in_valid,
        output ld_wr_en, ld_addr,
        output bf_rd_en, bf_addr_a, bf_addr_b, tw_idx, bf_stage,
        output bf_wr_en, bf_wr_a, bf_wr_b,
        output out_rd_en, out_addr, out_valid,
        output busy, in_drop
    );

    modport slave (
        output in_valid,
        input  ld_wr_en, ld_addr,
        input  bf_rd_en, bf_addr_a, bf_addr_b, tw_idx, bf_stage,
        input  bf_wr_en, bf_wr_a, bf_wr_b,
        input  out_rd_en, out_addr, out_valid,
        input  busy, in_drop
    );

endinterface

// File: rtl/fft256_bf_addr_gen.sv
// Combinational butterfly address generator: (stage, butterfly) -> upper/lower leg and twiddle.
// In stage s the legs are span = 128>>s apart and groups repeat every 2*span addresses.
module fft256_bf_addr_gen
    import fft256_pkg::*;
(
    input  logic [2:0] stage,
    input  logic [6:0] bfly,
    output addr_t      addr_a,
    output addr_t      addr_b,
    output tw_t        tw_idx
);

    addr_t span;
    addr_t pos;
    addr_t grp;

    always_comb begin
        span   = addr_t'(HALF) >> stage;
        pos    = {1'b0, bfly} & (span - 8'd1);
        grp    = {1'b0, bfly} >> (3'd7 - stage);
        addr_a = (grp << (4'd8 - {1'b0, stage})) | pos;
        addr_b = addr_a + span;
        tw_idx = tw_t'(pos << stage);
    end

endmodule

// File: rtl/fft256_seq_ctrl.sv
// Address/enable sequencer for the in-place 256-point radix-2 DIF FFT: load, 8 butterfly
// stages with delayed write-back, then bit-reversed read-out. Holds no sample data.
module fft256_seq_ctrl
    import fft256_pkg::*;
#(
    parameter int BF_LAT = 2,
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    fft256_seq_ctrl_if.master bus
);

    localparam addr_t      LD_LAST  = addr_t'(N - 1);
    localparam logic [6:0] BF_LAST  = 7'(HALF - 1);
    localparam logic [2:0] BF_DRAIN = 3'(BF_LAT - 1);
    localparam logic [2:0] RD_DRAIN = 3'(RD_LAT - 1);

    state_t     state;
    addr_t      ld_cnt;
    logic [6:0] bf_cnt;
    logic [2:0] stage;
    logic [2:0] lat_cnt;
    addr_t      out_cnt;

    logic       ld_wr_en;
    addr_t      ld_addr;
    logic       bf_rd_en;
    addr_t      bf_addr_a;
    addr_t      bf_addr_b;
    tw_t        tw_idx;
    logic [2:0] bf_stage;
    logic       out_rd_en;
    addr_t      out_addr;
    logic       busy;
    logic       in_drop;

    addr_t gen_a;
    addr_t gen_b;
    tw_t   gen_tw;

    logic [BF_LAT-1:0] wr_en_dly;
    addr_t             wr_a_dly [BF_LAT];
    addr_t             wr_b_dly [BF_LAT];
    logic [RD_LAT-1:0] ov_dly;

    fft256_bf_addr_gen u_addr_gen (
        .stage  (stage),
        .bfly   (bf_cnt),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    // Main sequencer; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ld_cnt    <= '0;
            bf_cnt    <= '0;
            stage     <= '0;
            lat_cnt   <= '0;
            out_cnt   <= '0;
            ld_wr_en  <= 1'b0;
            ld_addr   <= '0;
            bf_rd_en  <= 1'b0;
            bf_addr_a <= '0;
            bf_addr_b <= '0;
            tw_idx    <= '0;
            bf_stage  <= '0;
            out_rd_en <= 1'b0;
            out_addr  <= '0;
            busy      <= 1'b0;
            in_drop   <= 1'b0;
        end else begin
            ld_wr_en  <= 1'b0;
            bf_rd_en  <= 1'b0;
            out_rd_en <= 1'b0;
            in_drop   <= bus.in_valid && (state != IDLE) && (state != LOAD);

            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        ld_wr_en <= 1'b1;
                        ld_addr  <= '0;
                        ld_cnt   <= 8'd1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        ld_wr_en <= 1'b1;
                        ld_addr  <= ld_cnt;
                        ld_cnt   <= ld_cnt + 8'd1;
                        if (ld_cnt == LD_LAST) begin
                            state  <= CALC;
                            stage  <= '0;
                            bf_cnt <= '0;
                            busy   <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    bf_rd_en  <= 1'b1;
                    bf_addr_a <= gen_a;
                    bf_addr_b <= gen_b;
                    tw_idx    <= gen_tw;
                    bf_stage  <= stage;
                    bf_cnt    <= bf_cnt + 7'd1;
                    if (bf_cnt == BF_LAST) begin
                        state   <= DRAIN;
                        lat_cnt <= '0;
                    end
                end
                // Hold off the next stage until the last write-back of this one has landed.
                DRAIN: begin
                    if (lat_cnt == BF_DRAIN) begin
                        if (stage == 3'd7) begin
                            state   <= OUT;
                            out_cnt <= '0;
                        end else begin
                            state  <= CALC;
                            stage  <= stage + 3'd1;
                            bf_cnt <= '0;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                OUT: begin
                    out_rd_en <= 1'b1;
                    out_addr  <= bitrev8(out_cnt);
                    out_cnt   <= out_cnt + 8'd1;
                    if (out_cnt == LD_LAST) begin
                        state   <= TAIL;
                        lat_cnt <= '0;
                    end
                end
                TAIL: begin
                    if (lat_cnt == RD_DRAIN) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-back and output-valid lines are plain shift registers of the read strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_dly <= '0;
            ov_dly    <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                wr_a_dly[i] <= '0;
                wr_b_dly[i] <= '0;
            end
        end else begin
            wr_en_dly[0] <= bf_rd_en;
            wr_a_dly[0]  <= bf_addr_a;
            wr_b_dly[0]  <= bf_addr_b;
            for (int i = 1; i < BF_LAT; i++) begin
                wr_en_dly[i] <= wr_en_dly[i-1];
                wr_a_dly[i]  <= wr_a_dly[i-1];
                wr_b_dly[i]  <= wr_b_dly[i-1];
            end
            ov_dly[0] <= out_rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                ov_dly[i] <= ov_dly[i-1];
            end
        end
    end

    assign bus.ld_wr_en  = ld_wr_en;
    assign bus.ld_addr   = ld_addr;
    assign bus.bf_rd_en  = bf_rd_en;
    assign bus.bf_addr_a = bf_addr_a;
    assign bus.bf_addr_b = bf_addr_b;
    assign bus.tw_idx    = tw_idx;
    assign bus.bf_stage  = bf_stage;
    assign bus.bf_wr_en  = wr_en_dly[BF_LAT-1];
    assign bus.bf_wr_a   = wr_a_dly[BF_LAT-1];
    assign bus.bf_wr_b   = wr_b_dly[BF_LAT-1];
    assign bus.out_rd_en = out_rd_en;
    assign bus.out_addr  = out_addr;
    assign bus.out_valid = ov_dly[RD_LAT-1];
    assign bus.busy      = busy;
    assign bus.in_drop   = in_drop;

endmodule

// File: tb/tb_fft256_seq_ctrl.sv
// Self-checking bench for fft256_seq_ctrl: directed frames, a golden address model on every read,
// write-back/hazard tracking, bit-reversed output order and frame timing.
module tb_fft256_seq_ctrl;
    import fft256_pkg::*;

    localparam int BF_LAT = 2;
    localparam int RD_LAT = 1;
    localparam int FIRST_OV_DELAY = 1043;

    typedef struct {
        int stage;
        int bfly;
        int exp_a;
        int exp_b;
        int exp_tw;
    } addr_vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    fft256_seq_ctrl_if bus ();

    fft256_seq_ctrl #(.BF_LAT(BF_LAT), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [7:0] rev(input logic [7:0] k);
        return {k[0], k[1], k[2], k[3], k[4], k[5], k[6], k[7]};
    endfunction

    // Monitor state, observed on the falling edge.
    bit    mon_en = 1'b0;
    int    rd_count, wr_count, out_count, ov_count, ov_first, ov_last, drop_count;
    int    log_a [1024];
    int    log_b [1024];
    int    log_tw [1024];
    int    wr_done [256];
    logic  h_en [2];
    addr_t h_a [2];
    addr_t h_b [2];

    task automatic resetMonitor();
        rd_count = 0; wr_count = 0; out_count = 0; ov_count = 0;
        ov_first = 0; ov_last = 0; drop_count = 0;
        for (int i = 0; i < 256; i++) wr_done[i] = 0;
        for (int i = 0; i < 2; i++) begin
            h_en[i] = 1'b0; h_a[i] = '0; h_b[i] = '0;
        end
    endtask

    always @(negedge clk) begin
        int s, bi, half, blk, ea, eb, etw;
        if (mon_en) begin
            checkOutput("bf_wr_en delay", 64'(bus.bf_wr_en), 64'(h_en[1]));
            if (h_en[1]) begin
                checkOutput("bf_wr_a delay", 64'(bus.bf_wr_a), 64'(h_a[1]));
                checkOutput("bf_wr_b delay", 64'(bus.bf_wr_b), 64'(h_b[1]));
            end
            h_en[1] = h_en[0]; h_a[1] = h_a[0]; h_b[1] = h_b[0];
            h_en[0] = bus.bf_rd_en; h_a[0] = bus.bf_addr_a; h_b[0] = bus.bf_addr_b;

            if (bus.bf_rd_en) begin
                if (rd_count < 1024) begin
                    s    = rd_count / 128;
                    bi   = rd_count % 128;
                    half = 128 >> s;
                    blk  = 256 >> s;
                    ea   = (bi / half) * blk + (bi % half);
                    eb   = ea + half;
                    etw  = (bi % half) * (1 << s);
                    checkOutput("bf_addr_a", 64'(bus.bf_addr_a), 64'(ea));
                    checkOutput("bf_addr_b", 64'(bus.bf_addr_b), 64'(eb));
                    checkOutput("tw_idx", 64'(bus.tw_idx), 64'(etw));
                    checkOutput("bf_stage", 64'(bus.bf_stage), 64'(s));
                    checkOutput("hazard leg a", 64'(wr_done[ea]), 64'(s));
                    checkOutput("hazard leg b", 64'(wr_done[eb]), 64'(s));
                    log_a[rd_count]  = int'(bus.bf_addr_a);
                    log_b[rd_count]  = int'(bus.bf_addr_b);
                    log_tw[rd_count] = int'(bus.tw_idx);
                end
                rd_count++;
            end
            if (bus.bf_wr_en) begin
                wr_done[bus.bf_wr_a]++;
                wr_done[bus.bf_wr_b]++;
                wr_count++;
            end
            if (bus.out_rd_en) begin
                if (wr_count != 1024) checkOutput("write-back done before out read", 64'(wr_count), 64'(1024));
                checkOutput("out_addr", 64'(bus.out_addr), 64'(rev(out_count[7:0])));
                out_count++;
            end
            if (bus.out_valid) begin
                if (ov_count == 0) ov_first = cyc;
                ov_last = cyc;
                ov_count++;
            end
            if (bus.in_drop) drop_count++;
        end
    end

    task automatic checkAllZero(input string name);
        checkOutput({name, " group1"},
            64'({bus.ld_wr_en, bus.ld_addr, bus.bf_rd_en, bus.bf_addr_a, bus.bf_addr_b,
                 bus.tw_idx, bus.bf_stage, bus.bf_wr_en, bus.bf_wr_a}), 64'(0));
        checkOutput({name, " group2"},
            64'({bus.bf_wr_b, bus.out_rd_en, bus.out_addr, bus.out_valid, bus.busy, bus.in_drop}), 64'(0));
    endtask

    // Feed 256 samples; gap_mod=0 is back-to-back, else every gap_mod-th cycle is idle.
    task automatic applyStimulus(input int gap_mod, output int drive_cyc);
        int   nacc;
        logic v;
        nacc = 0;
        drive_cyc = 0;
        for (int i = 0; i < 1024 && nacc < 256; i++) begin
            v = (gap_mod == 0) || ((i % gap_mod) != (gap_mod - 1));
            bus.in_valid = v;
            if (v) drive_cyc = cyc;
            @(posedge clk); #1;
            checkOutput("ld_wr_en", 64'(bus.ld_wr_en), 64'(v));
            if (v) begin
                checkOutput("ld_addr", 64'(bus.ld_addr), 64'(nacc));
                nacc++;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 3000 && bus.busy; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("idle timeout", 64'(bus.busy), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("out_valid after frame", 64'(bus.out_valid), 64'(0));
    endtask

    task automatic checkFrame(input int drive_cyc, input int exp_drops);
        checkOutput("read count", 64'(rd_count), 64'(1024));
        checkOutput("write count", 64'(wr_count), 64'(1024));
        checkOutput("out_rd count", 64'(out_count), 64'(256));
        checkOutput("out_valid count", 64'(ov_count), 64'(256));
        checkOutput("out_valid contiguous", 64'(ov_last - ov_first), 64'(255));
        checkOutput("first out_valid delay", 64'(ov_first - drive_cyc), 64'(FIRST_OV_DELAY));
        checkOutput("in_drop count", 64'(drop_count), 64'(exp_drops));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got time %0t expected completion", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        addr_vec_t vecs [10];
        int drive_cyc;

        vecs[0] = '{0,   0,   0, 128,   0};
        vecs[1] = '{0, 127, 127, 255, 127};
        vecs[2] = '{1,   0,   0,  64,   0};
        vecs[3] = '{1,  65, 129, 193,   2};
        vecs[4] = '{2,  33,  65,  97,   4};
        vecs[5] = '{3, 100, 196, 212,  32};
        vecs[6] = '{4,  77, 149, 157,  80};
        vecs[7] = '{6, 127, 253, 255,  64};
        vecs[8] = '{7,   5,  10,  11,   0};
        vecs[9] = '{7, 127, 254, 255,   0};

        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset state");
        rst = 1'b0;
        @(posedge clk); #1;

        // Frame 1: back-to-back load, one dropped sample mid-CALC.
        resetMonitor();
        mon_en = 1'b1;
        applyStimulus(0, drive_cyc);
        checkOutput("busy after load", 64'(bus.busy), 64'(1));
        checkOutput("no read on CALC entry", 64'(bus.bf_rd_en), 64'(0));
        @(posedge clk); #1;
        checkOutput("first read en", 64'(bus.bf_rd_en), 64'(1));
        checkOutput("first read a", 64'(bus.bf_addr_a), 64'(0));
        checkOutput("first read b", 64'(bus.bf_addr_b), 64'(128));
        checkOutput("first read tw", 64'(bus.tw_idx), 64'(0));
        checkOutput("first read stage", 64'(bus.bf_stage), 64'(0));
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checkOutput("in_drop in CALC", 64'(bus.in_drop), 64'(1));
        checkOutput("no load write in CALC", 64'(bus.ld_wr_en), 64'(0));
        checkOutput("ld_addr held in CALC", 64'(bus.ld_addr), 64'(255));
        checkOutput("reads continue after drop", 64'(bus.bf_rd_en), 64'(1));
        @(posedge clk); #1;
        checkOutput("in_drop one pulse", 64'(bus.in_drop), 64'(0));
        waitIdle();
        checkFrame(drive_cyc, 1);
        for (int i = 0; i < 10; i++) begin
            int idx;
            idx = vecs[i].stage * 128 + vecs[i].bfly;
            checkOutput($sformatf("vec%0d a", i), 64'(log_a[idx]), 64'(vecs[i].exp_a));
            checkOutput($sformatf("vec%0d b", i), 64'(log_b[idx]), 64'(vecs[i].exp_b));
            checkOutput($sformatf("vec%0d tw", i), 64'(log_tw[idx]), 64'(vecs[i].exp_tw));
        end
        mon_en = 1'b0;

        // Frame 2: gapped load, then reset mid-CALC.
        applyStimulus(3, drive_cyc);
        checkOutput("busy after gapped load", 64'(bus.busy), 64'(1));
        repeat (50) @(posedge clk);
        #1;
        checkOutput("reading before reset", 64'(bus.bf_rd_en), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        checkAllZero("mid-CALC reset");
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("idle after reset busy", 64'(bus.busy), 64'(0));
        checkOutput("idle after reset rd", 64'(bus.bf_rd_en), 64'(0));

        // Frame 3: fresh full frame after the aborted one.
        resetMonitor();
        mon_en = 1'b1;
        applyStimulus(0, drive_cyc);
        waitIdle();
        checkFrame(drive_cyc, 0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
